// File: rtl/eee_vid_pkg.sv
// eee_vid_pkg: shared FSM states, packet codes, register map and pixel config for the video pattern source
package eee_vid_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL_HDR,
    S_CTRL_D0,
    S_CTRL_D1,
    S_CTRL_D2,
    S_VID_HDR,
    S_PIXELS,
    S_GAP
  } state_t;
  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] INTERLACE = 4'h3;
  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_BG      = 3'd1;
  localparam logic [2:0] A_BOX_TL  = 3'd2;
  localparam logic [2:0] A_BOX_BR  = 3'd3;
  localparam logic [2:0] A_BOX_COL = 3'd4;
  localparam logic [2:0] A_GAP     = 3'd5;
  localparam logic [2:0] A_FRAMES  = 3'd6;
  localparam logic [2:0] A_ID      = 3'd7;
  typedef struct packed {
    logic [1:0]  pattern;
    logic        box_en;
    logic [23:0] bg;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [23:0] box_col;
  } pix_cfg_t;
  // white,yellow,cyan,green,magenta,red,blue,black: R is off when i[1], G when i[2], B when i[0]
  function automatic logic [23:0] bar_colour(input logic [2:0] i);
    return {{8{~i[1]}}, {8{~i[2]}}, {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/eee_pattern_pixel.sv
// eee_pattern_pixel: combinational pixel colour at (x,y) from the frame's shadow config
//   x, y   : pixel coordinates
//   cfg    : pattern select, background, box rectangle and colour
//   pixel  : {R,G,B}
module eee_pattern_pixel
  import eee_vid_pkg::*;
#(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  pix_cfg_t    cfg,
  output logic [23:0] pixel
);
  logic [2:0]  bar;
  logic [7:0]  xy;
  logic        in_box;
  logic [23:0] bg_pix;
  always_comb begin
    bar = 3'({x, 3'b000} / {3'b000, IMAGE_W});
    xy = x[7:0] ^ y[7:0];
    // an inverted rectangle fails one of the compares, so it draws nothing
    in_box = cfg.box_en && x >= cfg.x0 && x <= cfg.x1 && y >= cfg.y0 && y <= cfg.y1;
    bg_pix = cfg.pattern == 2'd0 ? cfg.bg :
             cfg.pattern == 2'd1 ? bar_colour(bar) :
             cfg.pattern == 2'd2 ? {x[7:0], y[7:0], 8'h00} : {3{xy}};
    pixel = in_box ? cfg.box_col : bg_pix;
  end
endmodule

// File: rtl/eee_video_pattern_src.sv
// eee_video_pattern_src: Avalon-ST test-pattern frame source with an MM config slave
//   clk, reset_n        : clock, async active-low reset
//   s_*                 : MM slave (CTRL, BG, BOX_TL, BOX_BR, BOX_COL, GAP, FRAMES, ID)
//   source_*            : registered {R,G,B} stream with sop/eop and valid/ready
module eee_video_pattern_src
  import eee_vid_pkg::*;
#(
  parameter logic [10:0] IMAGE_W     = 11'd640,
  parameter logic [10:0] IMAGE_H     = 11'd480,
  parameter logic [15:0] GAP_DEFAULT = 16'd64,
  parameter logic [31:0] SRC_ID      = 32'h1234EEE3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop
);
  localparam logic [15:0] W16 = {5'b0, IMAGE_W};
  localparam logic [15:0] H16 = {5'b0, IMAGE_H};
  state_t      state_q, state_d;
  pix_cfg_t    cfg_q, cfg_d, sh_q, sh_d;
  logic        en_q, en_d, pkt_en_q, pkt_en_d;
  logic [15:0] gap_q, gap_d, sh_gap_q, sh_gap_d, gap_cnt_q, gap_cnt_d, frames_q, frames_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [23:0] data_q, data_d, pixel;
  logic [31:0] readdata_q, readdata_d;
  logic        advance, x_last, last_pix, unused_wd;
  assign unused_wd = ^s_writedata[31:27];
  // the output register may be refilled whenever it is empty or being consumed
  assign advance = ~valid_q | source_ready;
  assign x_last = x_q == IMAGE_W - 11'd1;
  assign last_pix = x_last && y_q == IMAGE_H - 11'd1;
  eee_pattern_pixel #(.IMAGE_W(IMAGE_W)) u_pix (.x(x_q), .y(y_q), .cfg(sh_q), .pixel(pixel));
  always_comb begin
    cfg_d = cfg_q;
    en_d = en_q;
    pkt_en_d = pkt_en_q;
    gap_d = gap_q;
    if (s_chipselect && s_write)
      case (s_address)
        A_CTRL:    {pkt_en_d, cfg_d.box_en, cfg_d.pattern, en_d} = s_writedata[4:0];
        A_BG:      cfg_d.bg = s_writedata[23:0];
        A_BOX_TL:  {cfg_d.x0, cfg_d.y0} = {s_writedata[26:16], s_writedata[10:0]};
        A_BOX_BR:  {cfg_d.x1, cfg_d.y1} = {s_writedata[26:16], s_writedata[10:0]};
        A_BOX_COL: cfg_d.box_col = s_writedata[23:0];
        A_GAP:     gap_d = s_writedata[15:0];
        default:   ;
      endcase
  end
  always_comb begin
    readdata_d = readdata_q;
    if (s_chipselect && s_read)
      case (s_address)
        A_CTRL:    readdata_d = {27'b0, pkt_en_q, cfg_q.box_en, cfg_q.pattern, en_q};
        A_BG:      readdata_d = {8'b0, cfg_q.bg};
        A_BOX_TL:  readdata_d = {5'b0, cfg_q.x0, 5'b0, cfg_q.y0};
        A_BOX_BR:  readdata_d = {5'b0, cfg_q.x1, 5'b0, cfg_q.y1};
        A_BOX_COL: readdata_d = {8'b0, cfg_q.box_col};
        A_GAP:     readdata_d = {16'b0, gap_q};
        A_FRAMES:  readdata_d = {16'b0, frames_q};
        default:   readdata_d = SRC_ID;
      endcase
  end
  // state_q names the beat that will be loaded into the output register next
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    sh_gap_d = sh_gap_q;
    gap_cnt_d = gap_cnt_q;
    frames_d = frames_q;
    x_d = x_q;
    y_d = y_q;
    valid_d = valid_q;
    data_d = data_q;
    sop_d = sop_q;
    eop_d = eop_q;
    if (advance) begin
      valid_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
      case (state_q)
        S_IDLE: if (en_q) begin
          sh_d = cfg_q;
          sh_gap_d = gap_q;
          state_d = pkt_en_q ? S_CTRL_HDR : S_VID_HDR;
        end
        S_CTRL_HDR: begin
          {valid_d, sop_d, data_d} = {2'b11, 20'b0, PKT_CTRL};
          state_d = S_CTRL_D0;
        end
        S_CTRL_D0: begin
          {valid_d, data_d} = {1'b1, 4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
          state_d = S_CTRL_D1;
        end
        S_CTRL_D1: begin
          {valid_d, data_d} = {1'b1, 4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
          state_d = S_CTRL_D2;
        end
        S_CTRL_D2: begin
          {valid_d, eop_d, data_d} = {2'b11, 4'h0, INTERLACE, 4'h0, H16[3:0], 4'h0, H16[7:4]};
          state_d = S_VID_HDR;
        end
        S_VID_HDR: begin
          {valid_d, sop_d, data_d} = {2'b11, 20'b0, PKT_VIDEO};
          x_d = '0;
          y_d = '0;
          state_d = S_PIXELS;
        end
        S_PIXELS: begin
          {valid_d, eop_d, data_d} = {1'b1, last_pix, pixel};
          x_d = x_last ? 11'd0 : x_q + 11'd1;
          y_d = x_last ? y_q + 11'd1 : y_q;
          gap_cnt_d = '0;
          state_d = last_pix ? S_GAP : S_PIXELS;
        end
        default: begin
          gap_cnt_d = gap_cnt_q + 16'd1;
          frames_d = gap_cnt_q == sh_gap_q ? frames_q + 16'd1 : frames_q;
          state_d = gap_cnt_q == sh_gap_q ? S_IDLE : S_GAP;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cfg_q <= '{box_col: 24'hFF0000, default: '0};
      sh_q <= '0;
      en_q <= 1'b0;
      pkt_en_q <= 1'b0;
      gap_q <= GAP_DEFAULT;
      sh_gap_q <= '0;
      gap_cnt_q <= '0;
      frames_q <= '0;
      x_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      sh_q <= sh_d;
      en_q <= en_d;
      pkt_en_q <= pkt_en_d;
      gap_q <= gap_d;
      sh_gap_q <= sh_gap_d;
      gap_cnt_q <= gap_cnt_d;
      frames_q <= frames_d;
      x_q <= x_d;
      y_q <= y_d;
      valid_q <= valid_d;
      data_q <= data_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      readdata_q <= readdata_d;
    end
  assign s_readdata = readdata_q;
  assign source_data = data_q;
  assign source_valid = valid_q;
  assign source_sop = sop_q;
  assign source_eop = eop_q;
endmodule

// File: tb/tb_eee_video_pattern_src.sv
// tb_eee_video_pattern_src: directed frame-level checks of the pattern source at 8x4
module tb_eee_video_pattern_src;
  typedef struct packed { logic [23:0] d; logic sop; logic eop; } beat_t;
  typedef struct {
    logic [31:0] ctrl, bg, tl, br, col;
    int x, y;
    logic [23:0] exp;
    string name;
  } vec_t;

  logic clk, reset_n;
  logic s_chipselect, s_read, s_write;
  logic [2:0] s_address;
  logic [31:0] s_writedata, s_readdata;
  logic [23:0] source_data;
  logic source_valid, source_ready, source_sop, source_eop;
  logic rand_rdy, rdy_const, rnd_rdy;

  int checks, errors, fexp;
  int vid_frames, idx, last_len, stab_viol;
  logic [3:0] hdr;
  logic [23:0] cur_pix[32], done_pix[32], ref_pix[32];
  beat_t beats[$];
  beat_t hold_b;
  logic hold_v;
  vec_t vecs[16];

  eee_video_pattern_src #(.IMAGE_W(11'd8), .IMAGE_H(11'd4), .GAP_DEFAULT(16'd8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end
  assign source_ready = rand_rdy ? rnd_rdy : rdy_const;

  // stream monitor: records transfers, rebuilds video frames, watches handshake stability
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_v = 1'b0;
      hdr = 4'hF;
    end else begin
      if (hold_v && (!source_valid || {source_data, source_sop, source_eop} != hold_b)) stab_viol++;
      hold_v = source_valid && !source_ready;
      hold_b = {source_data, source_sop, source_eop};
      if (source_valid && source_ready) begin
        beats.push_back(hold_b);
        if (source_sop) begin
          hdr = source_data[3:0];
          idx = 0;
        end else if (hdr == 4'h0) begin
          if (idx < 32) cur_pix[idx] = source_data;
          idx++;
          if (source_eop) begin
            done_pix = cur_pix;
            last_len = idx;
            vid_frames++;
            hdr = 4'hF;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    s_chipselect = 1'b1;
    s_write = 1'b1;
    s_address = a;
    s_writedata = d;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    s_chipselect = 1'b1;
    s_read = 1'b1;
    s_address = a;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_vid(input int target);
    for (int i = 0; i < 3000 && vid_frames < target; i++) @(posedge clk);
    chk("vid_frame_timeout", vid_frames, target);
  endtask

  task automatic wait_frames_reg(input int target);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 100; i++) begin
      rd(3'd6, v);
      if (v == target) break;
    end
    chk("frames_reg", v, target);
  endtask

  // enable for exactly one frame: the second write clears enable once the frame has latched
  task automatic run_frame(input logic [31:0] ctrl);
    int n;
    n = vid_frames;
    wr(3'd0, ctrl | 32'h1);
    wr(3'd0, ctrl & ~32'h1);
    wait_vid(n + 1);
    fexp++;
    wait_frames_reg(fexp);
  endtask

  initial begin
    logic [31:0] v;
    logic [23:0] p1;
    int n, hits, nb;
    checks = 0; errors = 0; fexp = 0;
    vid_frames = 0; idx = 0; last_len = 0; stab_viol = 0;
    hdr = 4'hF; hold_v = 1'b0;
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
    rand_rdy = 1'b0; rdy_const = 1'b1;
    //          ctrl   bg           tl            br            col          x  y  exp
    vecs[0]  = '{32'h0, 32'h123456, 32'h0,        32'h0,        32'h0,       3, 2, 24'h123456, "pat0_bg"};
    vecs[1]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       0, 0, 24'hFFFFFF, "bar_white"};
    vecs[2]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       1, 1, 24'hFFFF00, "bar_yellow"};
    vecs[3]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       2, 3, 24'h00FFFF, "bar_cyan"};
    vecs[4]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       3, 0, 24'h00FF00, "bar_green"};
    vecs[5]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       4, 2, 24'hFF00FF, "bar_magenta"};
    vecs[6]  = '{32'h2, 32'h0,      32'h0,        32'h0,        32'h0,       7, 3, 24'h000000, "bar_black"};
    vecs[7]  = '{32'h4, 32'h0,      32'h0,        32'h0,        32'h0,       5, 3, 24'h050300, "ramp_5_3"};
    vecs[8]  = '{32'h4, 32'h0,      32'h0,        32'h0,        32'h0,       7, 1, 24'h070100, "ramp_7_1"};
    vecs[9]  = '{32'h6, 32'h0,      32'h0,        32'h0,        32'h0,       5, 3, 24'h060606, "xor_5_3"};
    vecs[10] = '{32'h6, 32'h0,      32'h0,        32'h0,        32'h0,       7, 0, 24'h070707, "xor_7_0"};
    vecs[11] = '{32'h8, 32'h111111, 32'h00030001, 32'h00020002, 32'hFF00FF,  2, 1, 24'h111111, "box_inverted"};
    vecs[12] = '{32'h8, 32'h0,      32'h00060002, 32'h00640032, 32'h00FF00,  7, 3, 24'h00FF00, "box_clip_in"};
    vecs[13] = '{32'h8, 32'h0,      32'h00060002, 32'h00640032, 32'h00FF00,  5, 2, 24'h000000, "box_clip_out"};
    vecs[14] = '{32'hC, 32'h0,      32'h0,        32'h0,        32'hABCDEF,  0, 0, 24'hABCDEF, "box_on_ramp"};
    vecs[15] = '{32'hC, 32'h0,      32'h0,        32'h0,        32'hABCDEF,  1, 0, 24'h010000, "ramp_beside_box"};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_data", source_data, 0);
    chk("rst_readdata", s_readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd7, v); chk("id", v, 32'h1234EEE3);
    rd(3'd4, v); chk("rst_box_col", v, 32'h00FF0000);
    rd(3'd5, v); chk("rst_gap", v, 32'd8);
    rd(3'd6, v); chk("rst_frames", v, 0);
    rd(3'd0, v); chk("rst_ctrl", v, 0);

    // frame structure with ctrl packet; enable is cleared mid-frame, the frame must still complete
    wr(3'd0, 32'h11);
    for (int i = 0; i < 200 && beats.size() < 15; i++) @(posedge clk);
    wr(3'd0, 32'h10);
    wait_vid(1);
    rd(3'd6, v); chk("frames_during_gap", v, 0);
    fexp = 1;
    wait_frames_reg(1);
    repeat (60) @(posedge clk);
    chk("beat_count", beats.size(), 37);
    // W=8: D0 = {W[7:4],W[11:8],W[15:12]} = 000000, D1 = {H[11:8],H[15:12],W[3:0]} = 000008,
    // D2 = {3,H[3:0],H[7:4]} with H=4 = 030400
    for (int i = 0; i < 37; i++) begin
      logic [23:0] ed;
      ed = i == 0 ? 24'h00000F : i == 2 ? 24'h000008 : i == 3 ? 24'h030400 : 24'h000000;
      chk($sformatf("frame_beat%0d", i), {6'b0, beats[i]},
          {6'b0, ed, i == 0 || i == 4, i == 3 || i == 36});
    end
    rd(3'd6, v); chk("frames_after_disable", v, 1);

    foreach (vecs[i]) begin
      wr(3'd1, vecs[i].bg);
      wr(3'd2, vecs[i].tl);
      wr(3'd3, vecs[i].br);
      wr(3'd4, vecs[i].col);
      run_frame(vecs[i].ctrl);
      chk(vecs[i].name, done_pix[vecs[i].y * 8 + vecs[i].x], vecs[i].exp);
    end

    // box overlay: exactly the 2x2 square (2..3, 1..2) is painted
    wr(3'd1, 32'h202020);
    wr(3'd2, 32'h00020001);
    wr(3'd3, 32'h00030002);
    wr(3'd4, 32'hFF00FF);
    run_frame(32'h8);
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      bit in_b;
      in_b = (i % 8) >= 2 && (i % 8) <= 3 && (i / 8) >= 1 && (i / 8) <= 2;
      if (done_pix[i] == 24'hFF00FF) hits++;
      chk($sformatf("box_px%0d", i), done_pix[i], in_b ? 24'hFF00FF : 24'h202020);
    end
    chk("box_hits", hits, 4);

    // backpressure: xor pattern with ready=1 as reference, then with random ready
    run_frame(32'h6);
    ref_pix = done_pix;
    stab_viol = 0;
    rand_rdy = 1'b1;
    run_frame(32'h6);
    rand_rdy = 1'b0;
    chk("bp_len", last_len, 32);
    for (int i = 0; i < 32; i++) chk($sformatf("bp_px%0d", i), done_pix[i], ref_pix[i]);
    chk("bp_stable", stab_viol, 0);

    // mid-frame pattern change applies only from the next frame
    wr(3'd1, 32'h0);
    n = vid_frames;
    wr(3'd0, 32'h1);
    for (int i = 0; i < 500 && !(hdr == 4'h0 && idx >= 10); i++) @(posedge clk);
    wr(3'd0, 32'h5);
    wait_vid(n + 1);
    p1 = done_pix[29];
    wait_vid(n + 2);
    wr(3'd0, 32'h4);
    chk("midchg_cur_frame", p1, 24'h000000);
    chk("midchg_next_frame", done_pix[29], 24'h050300);
    fexp += 2;
    wait_frames_reg(fexp);

    // async reset in the middle of the pixel stream
    wr(3'd0, 32'h1);
    for (int i = 0; i < 500 && !(hdr == 4'h0 && idx >= 5); i++) @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", source_valid, 0);
    chk("arst_sop", source_sop, 0);
    chk("arst_eop", source_eop, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    rd(3'd0, v); chk("arst_ctrl", v, 0);
    rd(3'd6, v); chk("arst_frames", v, 0);
    repeat (5) @(posedge clk);
    chk("arst_quiet", source_valid, 0);
    nb = beats.size();
    wr(3'd0, 32'h1);
    for (int i = 0; i < 100 && beats.size() <= nb; i++) @(posedge clk);
    chk("arst_first_beat", {6'b0, beats[nb]}, {6'b0, 24'h000000, 1'b1, 1'b0});
    wr(3'd0, 32'h0);
    rd(3'd7, v); chk("arst_id", v, 32'h1234EEE3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
